// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: default widths, the x0 index
// and the memory-wait FSM state type.
package hazard_ctrl_pkg;

    localparam int DEF_REG_AW = 5;
    localparam int X0_IDX     = 0;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_MEM_WAIT = 1'b1
    } hz_state_e;

    // A zero-latency memory still needs a legal one-bit wait counter.
    function automatic int wcntWidth(input int lat);
        return (lat > 0) ? $clog2(lat + 1) : 1;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and pipeline-control outputs exchanged
// between the pipeline (master) and the hazard controller (slave).
interface hazard_ctrl_if
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] ifid_rs1;
    logic [REG_AW-1:0] ifid_rs2;
    logic              ifid_use_rs1;
    logic              ifid_use_rs2;
    logic              idex_mem_read;
    logic              idex_reg_write;
    logic [REG_AW-1:0] idex_rd;
    logic              exmem_mem_read;
    logic              exmem_reg_write;
    logic [REG_AW-1:0] exmem_rd;
    logic              branch_taken;

    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              pipe_freeze;
    logic [CNT_W-1:0]  stall_cycles;
    logic [CNT_W-1:0]  flush_count;

    modport master (
        output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_mem_read, idex_reg_write, idex_rd,
               exmem_mem_read, exmem_reg_write, exmem_rd, branch_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze,
               stall_cycles, flush_count
    );

    modport slave (
        input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
               idex_mem_read, idex_reg_write, idex_rd,
               exmem_mem_read, exmem_reg_write, exmem_rd, branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush, pipe_freeze,
               stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_cmp.sv
// Single source/destination RAW match: only a real read of a non-x0 register
// against a stage that actually writes it counts.
module hazard_ctrl_cmp
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW = DEF_REG_AW
) (
    input  logic [REG_AW-1:0] i_src,
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_rd,
    input  logic              i_wr,
    output logic              o_match
);

    assign o_match = i_use && i_wr && (i_rd != REG_AW'(X0_IDX)) && (i_src == i_rd);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, branch flushes, multi-cycle load
// freeze and saturating stall/flush counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int LOAD_LAT = 0,
    parameter int FWD_EN   = 1,
    parameter int CNT_W    = 32
) (
    input  logic           clk,
    input  logic           rst,
    hazard_ctrl_if.slave   io_hz
);

    localparam int WCNT_W = wcntWidth(LOAD_LAT);

    hz_state_e         r_state;
    logic [WCNT_W-1:0] r_wcnt;
    logic [CNT_W-1:0]  r_stallCycles;
    logic [CNT_W-1:0]  r_flushCount;

    logic [REG_AW-1:0] w_src [2];
    logic              w_use [2];
    logic [REG_AW-1:0] w_rd  [3];
    logic              w_wr  [3];
    logic [5:0]        w_hit;
    logic              w_loadUse;
    logic              w_rawStall;
    logic              w_freezeEntry;
    logic              w_freeze;
    logic              w_flush;
    logic              w_bubbleRaw;

    // Stage 0 is the load-only view of EX, stage 1 any EX writer, stage 2 any MEM writer.
    assign w_src[0] = io_hz.ifid_rs1;
    assign w_src[1] = io_hz.ifid_rs2;
    assign w_use[0] = io_hz.ifid_use_rs1;
    assign w_use[1] = io_hz.ifid_use_rs2;
    assign w_rd[0]  = io_hz.idex_rd;
    assign w_rd[1]  = io_hz.idex_rd;
    assign w_rd[2]  = io_hz.exmem_rd;
    assign w_wr[0]  = io_hz.idex_mem_read;
    assign w_wr[1]  = io_hz.idex_reg_write | io_hz.idex_mem_read;
    assign w_wr[2]  = io_hz.exmem_reg_write | io_hz.exmem_mem_read;

    for (genvar s = 0; s < 2; s++) begin : g_src
        for (genvar p = 0; p < 3; p++) begin : g_stage
            hazard_ctrl_cmp #(.REG_AW(REG_AW)) u_cmp (
                .i_src   (w_src[s]),
                .i_use   (w_use[s]),
                .i_rd    (w_rd[p]),
                .i_wr    (w_wr[p]),
                .o_match (w_hit[s*3+p])
            );
        end
    end

    assign w_loadUse     = w_hit[0] | w_hit[3];
    assign w_rawStall    = (FWD_EN != 0) ? w_loadUse : (|w_hit);
    assign w_freezeEntry = (LOAD_LAT > 0) && (r_state == ST_IDLE) && io_hz.exmem_mem_read;
    assign w_freeze      = !rst && ((r_state == ST_MEM_WAIT) || w_freezeEntry);
    assign w_flush       = !rst && !w_freeze && io_hz.branch_taken;
    assign w_bubbleRaw   = !rst && !w_freeze && !io_hz.branch_taken && w_rawStall;

    assign io_hz.pc_write     = !w_freeze && !w_bubbleRaw;
    assign io_hz.ifid_write   = !w_freeze && !w_bubbleRaw;
    assign io_hz.idex_bubble  = w_flush | w_bubbleRaw;
    assign io_hz.ifid_flush   = w_flush;
    assign io_hz.pipe_freeze  = w_freeze;
    assign io_hz.stall_cycles = rst ? '0 : r_stallCycles;
    assign io_hz.flush_count  = rst ? '0 : r_flushCount;

    // The entry cycle is the first freeze cycle, so MEM_WAIT covers the remaining LOAD_LAT-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_wcnt        <= '0;
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_freezeEntry && (LOAD_LAT > 1)) begin
                    r_state <= ST_MEM_WAIT;
                    r_wcnt  <= WCNT_W'(LOAD_LAT - 1);
                end
            end else begin
                r_wcnt <= r_wcnt - WCNT_W'(1);
                if (r_wcnt <= WCNT_W'(1)) begin
                    r_state <= ST_IDLE;
                end
            end
            if ((w_freeze || w_bubbleRaw) && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if (w_flush && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed check of two hazard_ctrl configurations (forwarding
// with a 3-cycle load, no forwarding with single-cycle memory) against a model.
module tb_hazard_ctrl;

    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct packed {
        logic       r;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic       idexMr;
        logic       idexRw;
        logic [4:0] idexRd;
        logic       exMr;
        logic       exRw;
        logic [4:0] exRd;
        logic       br;
    } stim_t;

    logic  clk = 1'b0;
    stim_t cur = '0;
    stim_t s;
    int    vectors = 0;
    int    errors  = 0;
    int    cycle   = 0;

    int fwdCfg [2] = '{1, 0};
    int latCfg [2] = '{3, 0};
    int freezeLeft [2];
    int stallCnt [2];
    int flushCnt [2];

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) ifA ();
    hazard_ctrl_if #(.REG_AW(5), .CNT_W(CW)) ifB ();

    assign ifA.ifid_rs1 = cur.rs1;          assign ifB.ifid_rs1 = cur.rs1;
    assign ifA.ifid_rs2 = cur.rs2;          assign ifB.ifid_rs2 = cur.rs2;
    assign ifA.ifid_use_rs1 = cur.u1;       assign ifB.ifid_use_rs1 = cur.u1;
    assign ifA.ifid_use_rs2 = cur.u2;       assign ifB.ifid_use_rs2 = cur.u2;
    assign ifA.idex_mem_read = cur.idexMr;  assign ifB.idex_mem_read = cur.idexMr;
    assign ifA.idex_reg_write = cur.idexRw; assign ifB.idex_reg_write = cur.idexRw;
    assign ifA.idex_rd = cur.idexRd;        assign ifB.idex_rd = cur.idexRd;
    assign ifA.exmem_mem_read = cur.exMr;   assign ifB.exmem_mem_read = cur.exMr;
    assign ifA.exmem_reg_write = cur.exRw;  assign ifB.exmem_reg_write = cur.exRw;
    assign ifA.exmem_rd = cur.exRd;         assign ifB.exmem_rd = cur.exRd;
    assign ifA.branch_taken = cur.br;       assign ifB.branch_taken = cur.br;

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .FWD_EN(1), .CNT_W(CW)) dutA (
        .clk   (clk),
        .rst   (cur.r),
        .io_hz (ifA)
    );

    hazard_ctrl #(.REG_AW(5), .LOAD_LAT(0), .FWD_EN(0), .CNT_W(CW)) dutB (
        .clk   (clk),
        .rst   (cur.r),
        .io_hz (ifB)
    );

    // One comparison: counted, and reported only when it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s cycle %0d: got %0d expected %0d", tag, cycle, observed, expected);
        end
    endtask

    function automatic bit readsReg(input logic [4:0] src, input logic used,
                                    input logic [4:0] rd, input logic writes);
        return used && writes && (rd != 5'd0) && (src == rd);
    endfunction

    // Drive a vector, compare both DUTs against the model, then advance the model one clock.
    task automatic applyStimulus(input stim_t v);
        bit loadUse, rawAll, raw, frozen, flush, bub;
        logic [31:0] obs [7];
        @(negedge clk);
        cur = v;
        #1;
        loadUse = readsReg(v.rs1, v.u1, v.idexRd, v.idexMr) || readsReg(v.rs2, v.u2, v.idexRd, v.idexMr);
        rawAll  = loadUse
               || readsReg(v.rs1, v.u1, v.idexRd, v.idexRw || v.idexMr)
               || readsReg(v.rs2, v.u2, v.idexRd, v.idexRw || v.idexMr)
               || readsReg(v.rs1, v.u1, v.exRd, v.exRw || v.exMr)
               || readsReg(v.rs2, v.u2, v.exRd, v.exRw || v.exMr);
        for (int k = 0; k < 2; k++) begin
            raw    = (fwdCfg[k] != 0) ? loadUse : rawAll;
            frozen = !v.r && ((freezeLeft[k] > 0) || ((latCfg[k] > 0) && v.exMr));
            flush  = !v.r && !frozen && v.br;
            bub    = !v.r && !frozen && !v.br && raw;
            if (k == 0) begin
                obs = '{ifA.pc_write, ifA.ifid_write, ifA.idex_bubble, ifA.ifid_flush,
                        ifA.pipe_freeze, ifA.stall_cycles, ifA.flush_count};
            end else begin
                obs = '{ifB.pc_write, ifB.ifid_write, ifB.idex_bubble, ifB.ifid_flush,
                        ifB.pipe_freeze, ifB.stall_cycles, ifB.flush_count};
            end
            checkOutput($sformatf("dut%0d pc_write", k), obs[0], !(frozen || bub));
            checkOutput($sformatf("dut%0d ifid_write", k), obs[1], !(frozen || bub));
            checkOutput($sformatf("dut%0d idex_bubble", k), obs[2], flush || bub);
            checkOutput($sformatf("dut%0d ifid_flush", k), obs[3], flush);
            checkOutput($sformatf("dut%0d pipe_freeze", k), obs[4], frozen);
            checkOutput($sformatf("dut%0d stall_cycles", k), obs[5], v.r ? 0 : stallCnt[k]);
            checkOutput($sformatf("dut%0d flush_count", k), obs[6], v.r ? 0 : flushCnt[k]);
            if (v.r) begin
                freezeLeft[k] = 0;
                stallCnt[k]   = 0;
                flushCnt[k]   = 0;
            end else begin
                if (freezeLeft[k] > 0) freezeLeft[k]--;
                else if ((latCfg[k] > 0) && v.exMr) freezeLeft[k] = latCfg[k] - 1;
                if ((frozen || bub) && stallCnt[k] < CMAX) stallCnt[k]++;
                if (flush && flushCnt[k] < CMAX) flushCnt[k]++;
            end
        end
        @(posedge clk);
        cycle++;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            freezeLeft[k] = 0;
            stallCnt[k]   = 0;
            flushCnt[k]   = 0;
        end

        s = '0; s.r = 1'b1;
        applyStimulus(s);
        applyStimulus(s);

        // Load-use on rs1, then x0 and unused-source variants that must not stall.
        s = '0; s.idexMr = 1'b1; s.idexRd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        applyStimulus(s);
        s = '0;
        applyStimulus(s);
        s = '0; s.idexMr = 1'b1; s.idexRd = 5'd0; s.rs1 = 5'd0; s.u1 = 1'b1;
        applyStimulus(s);
        s = '0; s.idexMr = 1'b1; s.idexRd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b0;
        applyStimulus(s);

        // ALU producer seen in EX then MEM: two bubbles without forwarding only.
        s = '0; s.idexRw = 1'b1; s.idexRd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
        applyStimulus(s);
        s = '0; s.exRw = 1'b1; s.exRd = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1;
        applyStimulus(s);

        // Three-cycle load freeze with branches arriving during it.
        s = '0; s.exMr = 1'b1; s.exRd = 5'd9;
        applyStimulus(s);
        s = '0; s.br = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        s = '0;
        applyStimulus(s);

        // Branch beats a simultaneous load-use stall.
        s = '0; s.br = 1'b1; s.idexMr = 1'b1; s.idexRd = 5'd5; s.rs1 = 5'd5; s.u1 = 1'b1;
        applyStimulus(s);

        // Reset in the second freeze cycle aborts the wait.
        s = '0; s.exMr = 1'b1; s.exRd = 5'd3;
        applyStimulus(s);
        s = '0; s.r = 1'b1;
        applyStimulus(s);
        s = '0;
        applyStimulus(s);
        applyStimulus(s);

        for (int n = 0; n < 800; n++) begin
            s.r      = ($urandom_range(0, 199) == 0);
            s.rs1    = 5'($urandom_range(0, 3));
            s.rs2    = 5'($urandom_range(0, 3));
            s.u1     = 1'($urandom);
            s.u2     = 1'($urandom);
            s.idexMr = ($urandom_range(0, 3) == 0);
            s.idexRw = 1'($urandom);
            s.idexRd = 5'($urandom_range(0, 3));
            s.exMr   = ($urandom_range(0, 7) == 0);
            s.exRw   = 1'($urandom);
            s.exRd   = 5'($urandom_range(0, 3));
            s.br     = ($urandom_range(0, 5) == 0);
            applyStimulus(s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
